// File: rtl/pause_pkg.sv
// ---------------------------------------------------------------------------
// pause_pkg
// Shared types and constants for the Flappy Bird pause controller.
//   pause_state_t : PAUSED / COUNT / RUN state encoding
//   DIGIT_W       : width of the countdown digit
//   cnt_width()   : counter width for a cycle count, never below 1 bit
// ---------------------------------------------------------------------------
package pause_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    COUNT  = 2'd1,
    RUN    = 2'd2
  } pause_state_t;

  // A parameter of 1 would give $clog2 == 0 and a zero-width counter,
  // so the width is clamped to one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pause_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer, debounce filter and rising-edge detector for one
// raw board input.
// Ports:
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset
//   raw    in  : raw asynchronous input
//   synced out : input after the 2-flop synchronizer (not debounced)
//   level  out : debounced level
//   rise   out : one-cycle pulse on a 0->1 change of level
// ---------------------------------------------------------------------------
module btn_debounce
  import pause_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic synced,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta;
  logic [CW-1:0] cnt;
  logic          level_q;

  // Classic two-flop synchronizer; only synced is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

  // The accepted level only follows synced after DB_CYCLES consecutive
  // cycles of disagreement. Any agreeing cycle restarts the count, so a
  // bounce shorter than the window never reaches the level. The counter
  // wraps back to zero at its terminal value instead of overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (synced != level) begin
      if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Delayed copy of the level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Both operands are flops, so the pulse is glitch-free and lasts one cycle.
  assign rise = level & ~level_q;

endmodule

// File: rtl/pause_ctrl.sv
// ---------------------------------------------------------------------------
// pause_ctrl
// Pause controller for the Flappy Bird game core. A debounced push-button
// toggles between running and paused. Resuming goes through a visible
// countdown before play restarts. The per-frame tick is gated so that the
// game only advances while running.
//
// Optional feature macro: PAUSE_SW_OVERRIDE_EN
//   When defined, a low slide switch forces PAUSED, clears the digit and
//   blocks button presses. When undefined, sw is ignored and no switch
//   synchronizer is built.
//
// Ports:
//   clk          in  : system clock
//   rst_n        in  : asynchronous active-low reset
//   btn          in  : raw pause button, active-high, asynchronous
//   sw           in  : raw slide switch, 0 requests a forced pause
//   frame_tick   in  : one-cycle pulse per game frame
//   pause        out : high whenever the game must freeze
//   frame_en     out : frame_tick gated by RUN
//   count_active out : high while the countdown runs
//   count_digit  out : current countdown digit, 0 when not counting
//   resume_pulse out : one-cycle pulse in the first RUN cycle
// ---------------------------------------------------------------------------
module pause_ctrl
  import pause_pkg::*;
#(
  parameter int DB_CYCLES   = 500000,
  parameter int SEC_CYCLES  = 50000000,
  parameter int COUNT_START = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  input  logic               sw,
  input  logic               frame_tick,
  output logic               pause,
  output logic               frame_en,
  output logic               count_active,
  output logic [DIGIT_W-1:0] count_digit,
  output logic               resume_pulse
);

  localparam int                SW_W        = cnt_width(SEC_CYCLES);
  localparam logic [SW_W-1:0]    STEP_LAST   = SW_W'(SEC_CYCLES - 1);
  localparam logic [DIGIT_W-1:0] START_DIGIT = DIGIT_W'(COUNT_START);

  pause_state_t    state;
  logic [SW_W-1:0] step_cnt;
  logic            press;
  logic            btn_synced;
  logic            btn_level;
  logic            force_pause;
  logic [1:0]      unused_btn;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn),
    .synced(btn_synced),
    .level (btn_level),
    .rise  (press)
  );

  assign unused_btn = {btn_synced, btn_level};

`ifdef PAUSE_SW_OVERRIDE_EN
  logic       sw_synced;
  logic       sw_level;
  logic       sw_rise;
  logic [1:0] unused_sw;

  // The override acts on the synchronized switch, not the debounced one,
  // so a forced pause lands within three edges of the switch falling.
  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sw),
    .synced(sw_synced),
    .level (sw_level),
    .rise  (sw_rise)
  );

  assign force_pause = ~sw_synced;
  assign unused_sw   = {sw_level, sw_rise};
`else
  logic unused_sw;

  assign force_pause = 1'b0;
  assign unused_sw   = sw;
`endif

  // Main FSM. State, digit, step counter and resume pulse all live here.
  // A forced pause overrides everything. Inside COUNT a press is tested
  // before the step wrap, so a press landing on the wrap cycle aborts the
  // countdown rather than advancing or finishing it. The step counter
  // wraps at SEC_CYCLES-1 and never counts past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PAUSED;
      count_digit  <= '0;
      step_cnt     <= '0;
      resume_pulse <= 1'b0;
    end else begin
      resume_pulse <= 1'b0;
      if (force_pause) begin
        state       <= PAUSED;
        count_digit <= '0;
        step_cnt    <= '0;
      end else begin
        case (state)
          PAUSED: begin
            if (press) begin
              state       <= COUNT;
              count_digit <= START_DIGIT;
              step_cnt    <= '0;
            end
          end
          COUNT: begin
            if (press) begin
              state       <= PAUSED;
              count_digit <= '0;
              step_cnt    <= '0;
            end else if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              if (count_digit > DIGIT_W'(1)) begin
                count_digit <= count_digit - DIGIT_W'(1);
              end else begin
                state        <= RUN;
                count_digit  <= '0;
                resume_pulse <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + SW_W'(1);
            end
          end
          RUN: begin
            if (press) begin
              state <= PAUSED;
            end
          end
          default: begin
            state       <= PAUSED;
            count_digit <= '0;
            step_cnt    <= '0;
          end
        endcase
      end
    end
  end

  // Output decode from the registered state; frame_en is combinational so
  // the game sees the tick in the same cycle it arrives.
  assign pause        = (state != RUN);
  assign count_active = (state == COUNT);
  assign frame_en     = frame_tick & (state == RUN);

endmodule

// File: tb/tb_pause_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pause_ctrl
// Directed self-checking bench for pause_ctrl with DB_CYCLES=4,
// SEC_CYCLES=10, COUNT_START=3. Inputs are driven and outputs sampled
// 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pause_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       sw;
  logic       frame_tick;
  logic       pause;
  logic       frame_en;
  logic       count_active;
  logic [1:0] count_digit;
  logic       resume_pulse;

  // {pause, count_active, count_digit[1:0], resume_pulse}
  logic [4:0] obs;
  assign obs = {pause, count_active, count_digit, resume_pulse};

  localparam logic [4:0] PAUSED_S = 5'b1_0_00_0;
  localparam logic [4:0] CNT3     = 5'b1_1_11_0;
  localparam logic [4:0] CNT2     = 5'b1_1_10_0;
  localparam logic [4:0] CNT1     = 5'b1_1_01_0;
  localparam logic [4:0] RUN1     = 5'b0_0_00_1;
  localparam logic [4:0] RUN_S    = 5'b0_0_00_0;

  int n_checks = 0;
  int n_fail   = 0;

  pause_ctrl #(
    .DB_CYCLES  (4),
    .SEC_CYCLES (10),
    .COUNT_START(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .sw          (sw),
    .frame_tick  (frame_tick),
    .pause       (pause),
    .frame_en    (frame_en),
    .count_active(count_active),
    .count_digit (count_digit),
    .resume_pulse(resume_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 1'b0; sw = 1'b1; frame_tick = 1'b0;
    wait_ticks(2);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL reset_state: got %b expected %b", obs, PAUSED_S); end
    frame_tick = 1'b1; #1;
    n_checks++; if (frame_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_en: got %b expected %b", frame_en, 1'b0); end
    frame_tick = 1'b0;
    rst_n = 1'b1;
    wait_ticks(3);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL post_reset_idle: got %b expected %b", obs, PAUSED_S); end
  endtask

  task automatic test_bounce();
    for (int len = 1; len <= 3; len++) begin
      btn = 1'b1; wait_ticks(len);
      btn = 1'b0; wait_ticks(12);
      n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL glitch_%0d: got %b expected %b", len, obs, PAUSED_S); end
    end
    // Clean press: 2 sync + 4 debounce edges, then the state edge at 7.
    btn = 1'b1; wait_ticks(6);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL press_early: got %b expected %b", obs, PAUSED_S); end
    wait_ticks(1);
    n_checks++; if (obs !== CNT3) begin n_fail++; $display("[TB] FAIL press_latency: got %b expected %b", obs, CNT3); end
    wait_ticks(1);
    btn = 1'b0;
  endtask

  // Continues from test_bounce: COUNT was entered one tick ago.
  task automatic test_countdown();
    logic [4:0] exp;
    for (int i = 2; i <= 30; i++) begin
      wait_ticks(1);
      exp = (i < 10) ? CNT3 : (i < 20) ? CNT2 : (i < 30) ? CNT1 : RUN1;
      n_checks++; if (obs !== exp) begin n_fail++; $display("[TB] FAIL countdown_t%0d: got %b expected %b", i, obs, exp); end
    end
    wait_ticks(1);
    n_checks++; if (obs !== RUN_S) begin n_fail++; $display("[TB] FAIL resume_one_cycle: got %b expected %b", obs, RUN_S); end
    for (int k = 0; k < 5; k++) begin
      frame_tick = (k == 0 || k == 2 || k == 3); #1;
      n_checks++; if (frame_en !== frame_tick) begin n_fail++; $display("[TB] FAIL run_frame_en_%0d: got %b expected %b", k, frame_en, frame_tick); end
      wait_ticks(1);
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_toggle();
    btn = 1'b1; wait_ticks(6);
    n_checks++; if (obs !== RUN_S) begin n_fail++; $display("[TB] FAIL toggle_early: got %b expected %b", obs, RUN_S); end
    wait_ticks(1);
    frame_tick = 1'b1; #1;
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL toggle_pause: got %b expected %b", obs, PAUSED_S); end
    n_checks++; if (frame_en !== 1'b0) begin n_fail++; $display("[TB] FAIL toggle_frame_en: got %b expected %b", frame_en, 1'b0); end
    frame_tick = 1'b0;
    wait_ticks(43);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL held_btn: got %b expected %b", obs, PAUSED_S); end
    btn = 1'b0; wait_ticks(15);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL held_release: got %b expected %b", obs, PAUSED_S); end
  endtask

  task automatic test_abort();
    // Abort while the digit reads 2.
    btn = 1'b1; wait_ticks(7);
    n_checks++; if (obs !== CNT3) begin n_fail++; $display("[TB] FAIL abort_enter: got %b expected %b", obs, CNT3); end
    wait_ticks(1); btn = 1'b0;
    wait_ticks(8); btn = 1'b1;
    wait_ticks(6);
    n_checks++; if (obs !== CNT2) begin n_fail++; $display("[TB] FAIL abort_pre: got %b expected %b", obs, CNT2); end
    wait_ticks(1);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL abort_digit2: got %b expected %b", obs, PAUSED_S); end
    wait_ticks(1); btn = 1'b0;
    wait_ticks(12);
    // Press lands on the final wrap edge (COUNT entry + 30).
    btn = 1'b1; wait_ticks(7);
    wait_ticks(1); btn = 1'b0;
    wait_ticks(22); btn = 1'b1;
    wait_ticks(6);
    n_checks++; if (obs !== CNT1) begin n_fail++; $display("[TB] FAIL wrap_pre: got %b expected %b", obs, CNT1); end
    wait_ticks(1);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL press_beats_wrap: got %b expected %b", obs, PAUSED_S); end
    wait_ticks(2); btn = 1'b0;
    wait_ticks(12);
  endtask

  task automatic test_reset_midcount();
    btn = 1'b1; wait_ticks(7);
    wait_ticks(1); btn = 1'b0;
    wait_ticks(11);
    n_checks++; if (obs !== CNT2) begin n_fail++; $display("[TB] FAIL midcount_pre: got %b expected %b", obs, CNT2); end
    rst_n = 1'b0; #2;
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL async_reset: got %b expected %b", obs, PAUSED_S); end
    frame_tick = 1'b1; #1;
    n_checks++; if (frame_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_gate: got %b expected %b", frame_en, 1'b0); end
    frame_tick = 1'b0;
    wait_ticks(2); rst_n = 1'b1;
    wait_ticks(12);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL after_reset: got %b expected %b", obs, PAUSED_S); end
  endtask

  task automatic test_sw_override();
    btn = 1'b1; wait_ticks(7);
    wait_ticks(1); btn = 1'b0;
    wait_ticks(2);
    sw = 1'b0; wait_ticks(3);
`ifdef PAUSE_SW_OVERRIDE_EN
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL sw_force: got %b expected %b", obs, PAUSED_S); end
    btn = 1'b1; wait_ticks(8); btn = 1'b0; wait_ticks(12);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL sw_press_ignored: got %b expected %b", obs, PAUSED_S); end
    sw = 1'b1; wait_ticks(10);
    n_checks++; if (obs !== PAUSED_S) begin n_fail++; $display("[TB] FAIL sw_stays_paused: got %b expected %b", obs, PAUSED_S); end
    btn = 1'b1; wait_ticks(7);
    n_checks++; if (obs !== CNT3) begin n_fail++; $display("[TB] FAIL sw_press_again: got %b expected %b", obs, CNT3); end
    wait_ticks(1); btn = 1'b0;
`else
    n_checks++; if (obs !== CNT3) begin n_fail++; $display("[TB] FAIL sw_ignored: got %b expected %b", obs, CNT3); end
    wait_ticks(8);
    n_checks++; if (obs !== CNT2) begin n_fail++; $display("[TB] FAIL sw_ignored_later: got %b expected %b", obs, CNT2); end
    sw = 1'b1;
`endif
    wait_ticks(4);
  endtask

  initial begin
    $display("[TB] pause_ctrl bench start");
    test_reset();
    test_bounce();
    test_countdown();
    test_toggle();
    test_abort();
    test_reset_midcount();
    test_sw_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
